// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: decodes a full-step coil pattern into step events, direction and position
// Ports: clk/rst (async active-high) | coil_in raw {A,B,C,D} | clear zeroes position and sticky errors
//        step_pulse/step_dir step event | position signed count | locked/coil_idle phase status
//        err_skip/err_illegal sticky errors | active step seen within last IDLE_CYCLES
module stepper_phase_decoder #(
  parameter int POS_WIDTH     = 16,
  parameter int FILTER_CYCLES = 4,
  parameter int IDLE_CYCLES   = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           coil_in,
  input  logic                 clear,
  output logic                 step_pulse,
  output logic                 step_dir,
  output logic [POS_WIDTH-1:0] position,
  output logic                 locked,
  output logic                 coil_idle,
  output logic                 err_skip,
  output logic                 err_illegal,
  output logic                 active
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] F_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] F_DONE = CW'(FILTER_CYCLES);
  localparam logic [IW-1:0] I_MAX  = IW'(IDLE_CYCLES);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t               state_q, state_d;
  logic [3:0]           s1_q, s2_q, cand_q;
  logic [CW-1:0]        cnt_q;
  logic                 accept, legal;
  logic [1:0]           idx_q, idx_d, new_idx, delta;
  logic                 step_q, step_d, dir_q, dir_d, cidle_q, cidle_d;
  logic                 skip_q, skip_d, ill_q, ill_d, new_skip, new_ill;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [IW-1:0]        idle_q;
  logic                 stepped_q;
  // The counter parks at FILTER_CYCLES once a run is accepted, so a long stable run strobes once.
  assign accept  = (s2_q == cand_q) && (cnt_q == F_LAST);
  assign legal   = cand_q inside {4'b1100, 4'b0110, 4'b0011, 4'b1001};
  assign new_idx = cand_q == 4'b0110 ? 2'd1 : cand_q == 4'b0011 ? 2'd2 : cand_q == 4'b1001 ? 2'd3 : 2'd0;
  assign delta   = new_idx - idx_q;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    cidle_d  = cidle_q;
    new_skip = 1'b0;
    new_ill  = 1'b0;
    if (accept) begin
      cidle_d = cand_q == 4'b0000;
      if (cand_q == 4'b0000) begin
        idx_d = idx_q;
      end else if (!legal) begin
        new_ill = 1'b1;
        state_d = UNLOCKED;
      end else if (state_q == UNLOCKED) begin
        state_d = LOCKED;
        idx_d   = new_idx;
      end else if (delta == 2'd2) begin
        new_skip = 1'b1;
        idx_d    = new_idx;
      end else if (delta != 2'd0) begin
        step_d = 1'b1;
        dir_d  = delta == 2'd1;
        idx_d  = new_idx;
        pos_d  = delta == 2'd1 ? pos_q + 1'b1 : pos_q - 1'b1;
      end
    end
    if (clear) pos_d = '0;
    skip_d = new_skip | (skip_q & ~clear);
    ill_d  = new_ill | (ill_q & ~clear);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      state_q   <= UNLOCKED;
      idx_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      cidle_q   <= 1'b0;
      skip_q    <= 1'b0;
      ill_q     <= 1'b0;
      idle_q    <= '0;
      stepped_q <= 1'b0;
    end else begin
      s1_q <= coil_in;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != F_DONE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      state_q   <= state_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      cidle_q   <= cidle_d;
      skip_q    <= skip_d;
      ill_q     <= ill_d;
      idle_q    <= step_d ? '0 : (idle_q != I_MAX ? idle_q + 1'b1 : idle_q);
      stepped_q <= stepped_q | step_d;
    end
  end
  assign step_pulse  = step_q;
  assign step_dir    = dir_q;
  assign position    = pos_q;
  assign locked      = state_q == LOCKED;
  assign coil_idle   = cidle_q;
  assign err_skip    = skip_q;
  assign err_illegal = ill_q;
  assign active      = stepped_q && (idle_q < I_MAX);
endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Monitors the 4-bit full-step coil pattern that the stepper drive path produces and decodes it back into step events, direction and a signed position count.
- Sits beside the claw's motor outputs, one instance per axis, so control logic and debug displays can track carriage position.
- Detects skipped or illegal coil patterns.
- Samples coil lines that may come from a slower divided-clock domain, so it synchronises and glitch-filters them first.

Parameters:
- POS_WIDTH, 16, width of the signed two's-complement position counter.
- FILTER_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted; legal range is 1 or more.
- IDLE_CYCLES, 1000000, clk cycles without a step before active deasserts; legal range is 1 or more.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- coil_in, input, 4, raw coil pattern {A,B,C,D}.
- clear, input, 1, synchronous; zeroes position and clears sticky errors.
- step_pulse, output, 1, one-cycle pulse per decoded step.
- step_dir, output, 1, direction of the last decoded step; 1 = forward.
- position, output, POS_WIDTH, signed step count.
- locked, output, 1, a reference phase is held.
- coil_idle, output, 1, the accepted pattern is 0000.
- err_skip, output, 1, sticky; a two-phase jump was seen.
- err_illegal, output, 1, sticky; a non-sequence, non-zero pattern was seen.
- active, output, 1, a step occurred within the last IDLE_CYCLES cycles.

Behaviour:
- Phase table: index 0 = 1100, 1 = 0110, 2 = 0011, 3 = 1001. Forward means the index increments mod 4.
- Reset values: all outputs 0, FSM in UNLOCKED, synchroniser and filter registers 0, idle counter 0.
- Input path:
  - Two-flop synchroniser on coil_in.
  - Filter holds a candidate pattern and a counter. If the synchronised value differs from the candidate, load the candidate and set the counter to 0. Otherwise, when the counter reaches FILTER_CYCLES-1, issue one accept strobe per stable run.
  - A pattern must therefore be stable for FILTER_CYCLES samples to be accepted.
- Latency: a coil_in change stable from edge N produces step_pulse high during the cycle after edge N+2+FILTER_CYCLES (registered output). The same latency applies to the position update and to all flag updates.
- FSM in UNLOCKED:
  - Accepted legal phase: latch its index, go to LOCKED, no step.
  - Accepted 0000: set coil_idle, stay UNLOCKED.
  - Accepted illegal pattern: set err_illegal, stay UNLOCKED.
- FSM in LOCKED, for each accept, with delta = (new - held) mod 4:
  - delta 1: step_pulse=1, step_dir=1, position+1.
  - delta 3: step_pulse=1, step_dir=0, position-1.
  - delta 0: no event.
  - delta 2: err_skip=1, latch the new index, stay LOCKED, no step, position unchanged.
  - 0000: coil_idle=1, keep the held index, stay LOCKED. The drive de-energises while disabled and resumes from the same phase.
  - Illegal pattern: err_illegal=1, go to UNLOCKED.
- locked = (state == LOCKED). coil_idle is cleared on the next accepted non-zero pattern.
- Position wraps modulo 2^POS_WIDTH; no saturation.
- clear behaviour:
  - clear has priority over a simultaneous step for position: position becomes 0. step_pulse and step_dir are still reported.
  - clear resets err_skip and err_illegal unless a new error is accepted in the same cycle; in that case the error flag ends at 1.
  - clear does not change FSM state or the held phase.
- Idle counter:
  - Reset to 0 on each step_pulse; otherwise increments and saturates at IDLE_CYCLES.
  - active = 1 while the counter is below IDLE_CYCLES and at least one step has occurred since reset.
- An asynchronous rst asserted mid-operation returns every register to its reset value immediately. The first accept after release requires a full FILTER_CYCLES stable run.
- Glitch rule: a pattern that is stable for fewer than FILTER_CYCLES samples is never accepted and produces no flag.

Test Plan:
- Reset, then drive 1100 for 10 cycles -> locked=1, position=0, no step_pulse, all errors 0.
- Sequence 1100→0110→0011→1001→1100, each held 8 cycles (FILTER_CYCLES=4) -> 4 step_pulses with step_dir=1, position=4. Each pulse arrives 7 cycles after the coil change.
- From position 0 at phase 0, apply 1001 then 0011 -> position=-2 (0xFFFE), step_dir=0. Then apply 1100 after 0011 -> err_skip=1, position unchanged.
- In LOCKED at 0110, drive a 2-cycle 0011 glitch, then 0110 -> no step, no error. Then 0000 for 10 cycles, then 0011 -> coil_idle=1 during the gap, followed by one forward step.
- Drive 1010 while LOCKED -> err_illegal=1, locked=0. Then 0110 -> relock with no step. Pulse clear in the same cycle as a subsequent step accept -> position=0, step_pulse=1, errors 0.
- With POS_WIDTH=4 at position 7, take one forward step -> position=-8. Assert rst mid-step -> all outputs 0 asynchronously. With IDLE_CYCLES=20, hold 20 cycles after a step -> active falls on cycle 20.
